// File: rtl/vae_pkg.sv
// ---------------------------------------------------------------------------
// vae_pkg
//   Shared definitions for the VAE fixed-point datapath.
//   - Default sample width, Q-format fractional bits and accumulator width.
//   - clog2(): constant-function ceiling log2, usable in port/parameter math.
//   - sat_max()/sat_min(): largest/smallest signed value of a given width,
//     returned as 64-bit so callers can cast them to their own width.
// ---------------------------------------------------------------------------
package vae_pkg;

    localparam int DATA_W_DEF = 32'sd16;
    localparam int FRAC_W_DEF = 32'sd8;
    localparam int ACC_W_DEF  = 32'sd24;

    // Ceiling log2; clog2(1) == 0, clog2(16) == 4, clog2(17) == 5.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Largest two's-complement value representable in w bits.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
    endfunction

    // Smallest two's-complement value representable in w bits.
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 32'sd1));
    endfunction

endpackage : vae_pkg

// File: rtl/accum_buffer_fxp_sat.sv
// ---------------------------------------------------------------------------
// fxp_sat
//   Combinational reduction of a signed ACC_W value to DATA_W bits.
//   Build option (macro): ACC_SAT_EN
//     defined   : clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1], sat flags a clamp
//     undefined : keep the low DATA_W bits (wrap), sat is always 0
//   Ports:
//     din  in  ACC_W   signed value to reduce
//     dout out DATA_W  reduced value
//     sat  out 1       dout differs from din because it was clamped
// ---------------------------------------------------------------------------
module fxp_sat
    import vae_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [ACC_W-1:0]  din,
    output logic [DATA_W-1:0] dout,
    output logic              sat
);

`ifdef ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(sat_min(DATA_W));

    logic signed [ACC_W-1:0]  din_s;
    logic        [DATA_W-1:0] clamp_s;
    logic                     over_s;

    assign din_s = $signed(din);

    // Clamp candidate and overflow flag, then pick clamp or wrap by build option.
    always_comb begin
        clamp_s = din[DATA_W-1:0];
        over_s  = 1'b0;
        if (din_s > MAX_S) begin
            clamp_s = MAX_S[DATA_W-1:0];
            over_s  = 1'b1;
        end else if (din_s < MIN_S) begin
            clamp_s = MIN_S[DATA_W-1:0];
            over_s  = 1'b1;
        end else begin
            clamp_s = din[DATA_W-1:0];
            over_s  = 1'b0;
        end

        if (SAT_EN) begin
            dout = clamp_s;
            sat  = over_s;
        end else begin
            dout = din[DATA_W-1:0];
            sat  = 1'b0;
        end
    end

endmodule : fxp_sat

// File: rtl/accum_buffer.sv
// ---------------------------------------------------------------------------
// accum_buffer
//   Accumulate-and-dump buffer: sums DEPTH signed samples from a valid/ready
//   stream and presents the sum (or mean, MEAN_MODE=1) on a registered
//   valid/ready output. Result reduction to DATA_W is done by fxp_sat, whose
//   behaviour is selected by the ACC_SAT_EN macro (clamp) or its absence (wrap).
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     clear      in   synchronous flush of the partial window
//     in_valid   in   sample valid
//     in_ready   out  sample accepted when in_valid & in_ready (combinational)
//     in_data    in   DATA_W signed sample
//     out_valid  out  result valid, held until accepted
//     out_ready  in   consumer accepts the result
//     out_data   out  DATA_W window result
//     out_sat    out  result was clipped
//     win_count  out  samples accepted in the current window
//   FRAC_W documents the Q format only; it does not affect arithmetic.
// ---------------------------------------------------------------------------
module accum_buffer
    import vae_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int DEPTH     = 32'sd16,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MEAN_MODE = 32'sd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sat,
    output logic [clog2(DEPTH)-1:0]   win_count
);

    localparam int CNT_W = clog2(DEPTH);

    // Elaboration-time parameter sanity.
    if (ACC_W < DATA_W + CNT_W) begin : g_bad_acc_w
        $error("accum_buffer: ACC_W too narrow for DATA_W and DEPTH");
    end
    if ((DEPTH < 2) || (DEPTH > 256) || ((32'sd1 <<< CNT_W) != DEPTH)) begin : g_bad_depth
        $error("accum_buffer: DEPTH must be a power of two in 2..256");
    end
    if ((FRAC_W < 0) || (FRAC_W >= DATA_W)) begin : g_bad_frac_w
        $error("accum_buffer: FRAC_W must lie in 0..DATA_W-1");
    end

    logic signed [ACC_W-1:0]  acc_r;
    logic        [CNT_W-1:0]  win_count_r;
    logic                     out_valid_r;
    logic        [DATA_W-1:0] out_data_r;
    logic                     out_sat_r;

    logic signed [ACC_W-1:0]  ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  scaled_s;
    logic        [DATA_W-1:0] red_data_s;
    logic                     red_sat_s;
    logic                     last_s;
    logic                     accept_s;
    logic                     load_s;

    assign ext_s  = $signed({{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data});
    assign sum_s  = acc_r + ext_s;
    assign last_s = (win_count_r == CNT_W'(DEPTH - 1));

    // Only the closing sample stalls, and only while the previous result is
    // still held; clear blocks input so nothing is accepted then discarded.
    assign in_ready = !clear && !(last_s && out_valid_r && !out_ready);
    assign accept_s = in_valid && in_ready;
    assign load_s   = accept_s && last_s;

    // Mean mode divides by DEPTH with an arithmetic shift (floor).
    always_comb begin
        scaled_s = sum_s;
        if (MEAN_MODE != 0) begin
            scaled_s = sum_s >>> CNT_W;
        end else begin
            scaled_s = sum_s;
        end
    end

    fxp_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_fxp_sat (
        .din  (scaled_s),
        .dout (red_data_s),
        .sat  (red_sat_s)
    );

    // Window state: accumulator and sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= '0;
            win_count_r <= '0;
        end else if (clear) begin
            acc_r       <= '0;
            win_count_r <= '0;
        end else if (accept_s) begin
            if (last_s) begin
                acc_r       <= '0;
                win_count_r <= '0;
            end else begin
                acc_r       <= sum_s;
                win_count_r <= win_count_r + CNT_W'(1'b1);
            end
        end else begin
            acc_r       <= acc_r;
            win_count_r <= win_count_r;
        end
    end

    // Output register: a new result has priority over draining the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= red_data_s;
            out_sat_r   <= red_sat_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_sat_r   <= out_sat_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sat_r   <= out_sat_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign win_count = win_count_r;

endmodule : accum_buffer
